// File: rtl/sdram_ctrl_module.sv
// Sequencer/arbiter in front of the SDRAM function block: one-shot init, periodic refresh,
// and fixed-priority arbitration of page-read, write and single-read requesters onto a one-hot call bus.
module sdram_ctrl_module #(
  parameter logic [13:0] REF_PERIOD = 14'd1500
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  oCall,
  input  logic        iDone,
  output logic [23:0] oAddr,
  output logic [23:0] oAddrPage,
  output logic [15:0] oWrData,
  input  logic [15:0] iRdData,
  input  logic        iPageReq,
  input  logic [23:0] iPageAddr,
  output logic        oPageAck,
  input  logic        iWrReq,
  input  logic [23:0] iWrAddr,
  input  logic [15:0] iWrData,
  output logic        oWrAck,
  input  logic        iRdReq,
  input  logic [23:0] iRdAddr,
  output logic [15:0] oRdData,
  output logic        oRdAck,
  output logic        oInitDone
);

  typedef enum logic [2:0] {INIT, IDLE, REFRESH, PAGE, WRITE, READ} stateType;

  localparam logic [4:0] CALL_INIT    = 5'b00001;
  localparam logic [4:0] CALL_REFRESH = 5'b00010;
  localparam logic [4:0] CALL_READ    = 5'b00100;
  localparam logic [4:0] CALL_WRITE   = 5'b01000;
  localparam logic [4:0] CALL_PAGE    = 5'b10000;

  stateType    state, stateNext;
  logic [4:0]  callNext;
  logic [23:0] addrNext, addrPageNext;
  logic [15:0] wrDataNext, rdDataNext;
  logic        pageAckNext, wrAckNext, rdAckNext, initDoneNext;
  logic [13:0] refCnt, refCntNext;
  logic        refPending, refPendingNext, refWrap;

  // Next-state and next-output logic; every output is registered so the call drop
  // lands one cycle after the done pulse, as the function block expects.
  always_comb begin
    stateNext      = state;
    callNext       = oCall;
    addrNext       = oAddr;
    addrPageNext   = oAddrPage;
    wrDataNext     = oWrData;
    rdDataNext     = oRdData;
    pageAckNext    = 1'b0;
    wrAckNext      = 1'b0;
    rdAckNext      = 1'b0;
    initDoneNext   = oInitDone;
    refPendingNext = refPending;
    refWrap        = oInitDone && (refCnt == REF_PERIOD - 14'd1);
    refCntNext     = (!oInitDone || refWrap) ? 14'd0 : refCnt + 14'd1;

    case (state)
      INIT: begin
        if (iDone) begin
          callNext     = 5'b00000;
          initDoneNext = 1'b1;
          stateNext    = IDLE;
        end
      end
      IDLE: begin
        if (refPending) begin
          stateNext      = REFRESH;
          callNext       = CALL_REFRESH;
          refPendingNext = 1'b0;
        end else if (iPageReq) begin
          stateNext    = PAGE;
          callNext     = CALL_PAGE;
          addrNext     = iPageAddr;
          addrPageNext = iPageAddr;
        end else if (iWrReq) begin
          stateNext  = WRITE;
          callNext   = CALL_WRITE;
          addrNext   = iWrAddr;
          wrDataNext = iWrData;
        end else if (iRdReq) begin
          stateNext = READ;
          callNext  = CALL_READ;
          addrNext  = iRdAddr;
        end
      end
      REFRESH, PAGE, WRITE, READ: begin
        if (iDone) begin
          callNext    = 5'b00000;
          stateNext   = IDLE;
          pageAckNext = (state == PAGE);
          wrAckNext   = (state == WRITE);
          rdAckNext   = (state == READ);
          if (state == READ) rdDataNext = iRdData;
        end
      end
      default: begin
        callNext  = 5'b00000;
        stateNext = IDLE;
      end
    endcase

    // A wrap in the same cycle as a refresh grant keeps the request alive.
    if (refWrap) refPendingNext = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      oCall      <= CALL_INIT;
      oAddr      <= 24'd0;
      oAddrPage  <= 24'd0;
      oWrData    <= 16'd0;
      oRdData    <= 16'd0;
      oPageAck   <= 1'b0;
      oWrAck     <= 1'b0;
      oRdAck     <= 1'b0;
      oInitDone  <= 1'b0;
      refCnt     <= 14'd0;
      refPending <= 1'b0;
    end else begin
      state      <= stateNext;
      oCall      <= callNext;
      oAddr      <= addrNext;
      oAddrPage  <= addrPageNext;
      oWrData    <= wrDataNext;
      oRdData    <= rdDataNext;
      oPageAck   <= pageAckNext;
      oWrAck     <= wrAckNext;
      oRdAck     <= rdAckNext;
      oInitDone  <= initDoneNext;
      refCnt     <= refCntNext;
      refPending <= refPendingNext;
    end
  end

endmodule
